median_window_gen: RTL and testbench

- Pixel-stream front end for the 3x3 median filter: turns a raster-order pixel stream into row-major 3x3 windows.
- Outputs arr_0..arr_8 connect by name to the median block's inputs; arr_0 is top-left, arr_4 is centre, arr_8 is bottom-right.
- Two line buffers plus a 3x3 register window; emits interior windows only (no border padding), with valid/ready handshakes on both sides.

---
 rtl/median_window_gen.sv | 148 ++++++++++++++
 tb/tb_median_window_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_gen.sv
// Raster pixel stream to row-major 3x3 interior windows for the median filter.
// Optional MEDIAN_WINDOW_GEN_SOF_EN adds in_sof to force a pixel to frame position (0,0).
module median_window_gen #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_pix,
  input  logic             in_valid,
`ifdef MEDIAN_WINDOW_GEN_SOF_EN
  input  logic             in_sof,
`endif
  output logic             in_ready,
  output logic [WIDTH-1:0] arr_0,
  output logic [WIDTH-1:0] arr_1,
  output logic [WIDTH-1:0] arr_2,
  output logic [WIDTH-1:0] arr_3,
  output logic [WIDTH-1:0] arr_4,
  output logic [WIDTH-1:0] arr_5,
  output logic [WIDTH-1:0] arr_6,
  output logic [WIDTH-1:0] arr_7,
  output logic [WIDTH-1:0] arr_8,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);

  logic [CW-1:0]    col_q, col_d, col_cur;
  logic [RW-1:0]    row_q, row_d, row_cur;
  logic [WIDTH-1:0] win_q [9];
  logic [WIDTH-1:0] win_d [9];
  logic [WIDTH-1:0] arr_q [9];
  logic [WIDTH-1:0] arr_d [9];
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic [WIDTH-1:0] lb0_mem [IMG_W];
  logic [WIDTH-1:0] lb1_mem [IMG_W];
  logic [WIDTH-1:0] lb0_rd, lb1_rd;

  logic accept, xfer, load;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    col_cur = col_q;
    row_cur = row_q;
`ifdef MEDIAN_WINDOW_GEN_SOF_EN
    if (in_sof) begin
      col_cur = '0;
      row_cur = '0;
    end
`endif
  end

  assign lb0_rd = lb0_mem[col_cur];
  assign lb1_rd = lb1_mem[col_cur];
  assign load   = accept && (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);

  // Position counters and 3x3 shift window
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (accept) begin
      for (int k = 0; k < 3; k++) begin
        win_d[3*k]     = win_q[3*k + 1];
        win_d[3*k + 1] = win_q[3*k + 2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = in_pix;
      if (col_cur == COL_MAX) begin
        col_d = '0;
        row_d = (row_cur == ROW_MAX) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
  end

  // Single output stage: a load overrides the clear so windows stream without bubbles
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    arr_d       = arr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_last_d  = (row_cur == ROW_MAX) && (col_cur == COL_MAX);
      arr_d       = win_d;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
        arr_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      win_q       <= win_d;
      arr_q       <= arr_d;
    end
  end

  // Line buffers are plain RAM; stale rows are overwritten before any window uses them
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[col_cur] <= lb0_rd;
      lb0_mem[col_cur] <= in_pix;
    end
  end

  assign arr_0     = arr_q[0];
  assign arr_1     = arr_q[1];
  assign arr_2     = arr_q[2];
  assign arr_3     = arr_q[3];
  assign arr_4     = arr_q[4];
  assign arr_5     = arr_q[5];
  assign arr_6     = arr_q[6];
  assign arr_7     = arr_q[7];
  assign arr_8     = arr_q[8];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_median_window_gen.sv
// Self-checking bench for median_window_gen: image-array reference model plus literal frame checks.
module tb_median_window_gen;

  localparam int W  = 8;
  localparam int IW = 5;
  localparam int IH = 4;
`ifdef MEDIAN_WINDOW_GEN_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_pix;
  logic         in_valid;
  logic         in_sof_r;
  logic         in_ready;
  logic [W-1:0] arr_0, arr_1, arr_2, arr_3, arr_4, arr_5, arr_6, arr_7, arr_8;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  median_window_gen #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(in_valid),
`ifdef MEDIAN_WINDOW_GEN_SOF_EN
    .in_sof(in_sof_r),
`endif
    .in_ready(in_ready),
    .arr_0(arr_0), .arr_1(arr_1), .arr_2(arr_2), .arr_3(arr_3), .arr_4(arr_4),
    .arr_5(arr_5), .arr_6(arr_6), .arr_7(arr_7), .arr_8(arr_8),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  wire [71:0] dut_win = {arr_0, arr_1, arr_2, arr_3, arr_4, arr_5, arr_6, arr_7, arr_8};

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pk9(input int a, b, c, d, e, f, g, h, i);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  function automatic int med9(input logic [71:0] w);
    int v[9];
    int t;
    for (int i = 0; i < 9; i++) v[i] = int'(w[71-8*i -: 8]);
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  // Reference model: frame image indexed by position plus a one-deep output slot
  int          img [IH][IW];
  int          pr, pc;
  logic        m_valid, m_last;
  logic [71:0] m_win;
  logic [72:0] got_q [$];
  bit          rnd_ready = 1'b0;

  function automatic logic [72:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : '1;
  endfunction

  always @(negedge clk) begin
    bit acc, xf;
    if (rst) begin
      pr = 0; pc = 0; m_valid = 1'b0; m_last = 1'b0; m_win = '0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_arr", dut_win, 72'd0);
      chk("rst_in_ready", in_ready, 1'b1);
    end else begin
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("window", dut_win, m_win);
        chk("out_last", out_last, m_last);
      end
      acc = in_valid && (!m_valid || out_ready);
      xf  = m_valid && out_ready;
      if (xf) got_q.push_back({out_last, dut_win});
      if (xf) m_valid = 1'b0;
      if (acc) begin
        if (SOF_EN && in_sof_r) begin pr = 0; pc = 0; end
        img[pr][pc] = int'(in_pix);
        if (pr >= 2 && pc >= 2) begin
          for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
              m_win[71 - 8*(3*k+j) -: 8] = 8'(img[pr-2+k][pc-2+j]);
          m_last  = (pr == IH-1) && (pc == IW-1);
          m_valid = 1'b1;
        end
        pc++;
        if (pc == IW) begin
          pc = 0; pr++;
          if (pr == IH) pr = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_pix(input logic [7:0] v, input bit sof);
    int n = 0;
    in_valid = 1'b1; in_pix = v; in_sof_r = sof;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof_r = 1'b0;
  endtask

  task automatic send_frame(input int base, input int drop, input bit sof);
    for (int p = 0; p < IW*IH; p++)
      if (p != drop) send_pix(8'(base + p + 1), sof && (p == 0));
  endtask

  task automatic drain();
    int n = 0;
    rnd_ready = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    while (out_valid && n < 100) begin @(negedge clk); n++; end
    if (out_valid) chk("drain_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  logic [7:0] rf [IH][IW];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pix = '0; in_sof_r = 1'b0; out_ready = 1'b1;
    #12;
    chk("init_in_ready", in_ready, 1'b1);
    chk("init_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Continuous frame
    got_q.delete();
    send_frame(0, -1, 1'b0);
    drain();
    chk("s1_count", got_q.size(), 6);
    chk("s1_first", got_at(0), {1'b0, pk9(1, 2, 3, 6, 7, 8, 11, 12, 13)});
    chk("s1_last", got_at(5), {1'b1, pk9(8, 9, 10, 13, 14, 15, 18, 19, 20)});
    chk("s1_median", med9(got_at(0)), 7);

    // Backpressure on the first window
    got_q.delete();
    out_ready = 1'b0;
    for (int p = 0; p < 13; p++) send_pix(8'(p + 1), 1'b0);
    in_valid = 1'b1; in_pix = 8'd14;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold", dut_win, pk9(1, 2, 3, 6, 7, 8, 11, 12, 13));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int p = 13; p < 20; p++) send_pix(8'(p + 1), 1'b0);
    drain();
    chk("bp_count", got_q.size(), 6);
    chk("bp_second", got_at(1), {1'b0, pk9(2, 3, 4, 7, 8, 9, 12, 13, 14)});

    // Two frames back to back
    got_q.delete();
    send_frame(0, -1, 1'b0);
    send_frame(100, -1, 1'b0);
    drain();
    chk("ff_count", got_q.size(), 12);
    chk("ff_second_first", got_at(6), {1'b0, pk9(101, 102, 103, 106, 107, 108, 111, 112, 113)});
    chk("ff_second_last", got_at(11), {1'b1, pk9(108, 109, 110, 113, 114, 115, 118, 119, 120)});

    // Asynchronous reset mid-frame
    for (int p = 0; p < 9; p++) send_pix(8'(p + 1), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_last", out_last, 1'b0);
    chk("arst_arr", dut_win, 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    send_frame(0, -1, 1'b0);
    drain();
    chk("arst_count", got_q.size(), 6);
    chk("arst_first", got_at(0), {1'b0, pk9(1, 2, 3, 6, 7, 8, 11, 12, 13)});
    chk("arst_last", got_at(5), {1'b1, pk9(8, 9, 10, 13, 14, 15, 18, 19, 20)});

    // Random frames with idle gaps and random backpressure, checked against a software median
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++) rf[r][c] = 8'($urandom_range(0, 255));
      got_q.delete();
      rnd_ready = 1'b1;
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++) begin
          repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0; in_pix = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
          end
          send_pix(rf[r][c], 1'b0);
        end
      drain();
      chk("rnd_count", got_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
        logic [71:0] nb;
        int cr, cc;
        cr = 1 + i / 3; cc = 1 + i % 3;
        for (int k = 0; k < 3; k++)
          for (int j = 0; j < 3; j++) nb[71 - 8*(3*k+j) -: 8] = rf[cr-1+k][cc-1+j];
        chk("rnd_median", med9(got_at(i)), med9(nb));
      end
    end

`ifdef MEDIAN_WINDOW_GEN_SOF_EN
    // Dropped pixel then resynchronise with in_sof
    got_q.delete();
    send_frame(0, 6, 1'b0);
    drain();
    chk("sof_corrupt_le6", got_q.size() <= 6, 1'b1);
    got_q.delete();
    send_frame(0, -1, 1'b1);
    drain();
    chk("sof_count", got_q.size(), 6);
    chk("sof_first", got_at(0), {1'b0, pk9(1, 2, 3, 6, 7, 8, 11, 12, 13)});
    chk("sof_last", got_at(5), {1'b1, pk9(8, 9, 10, 13, 14, 15, 18, 19, 20)});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
